// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin two-port arbiter and access sequencer for the
//                single-ported data memory (IDLE -> ACC -> RESP per access)
// Revision 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        done0,
  output logic        err0,
  output logic [31:0] rdata0,

  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic        err1,
  output logic [31:0] rdata1,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err0_q,  err0_d;
  logic        err1_q,  err1_d;

  logic        any_req;
  logic        winner;
  logic        in_range;
  logic        in_acc;
  logic        in_resp;
  logic [31:0] rd_result;

  assign any_req = req0 | req1;
  // On a tie the requester that did not win last time gets the memory.
  assign winner  = (req0 & req1) ? ~last_q : req1;

  assign in_range  = (addr_q[31:ADDR_W] == '0);
  assign rd_result = (~we_q & in_range) ? mem_rdata : 32'd0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          last_d  = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (owner_q) begin
          rdata1_d = rd_result;
          err1_d   = ~in_range;
        end else begin
          rdata0_d = rd_result;
          err0_d   = ~in_range;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // Memory-facing signals are forced to zero outside the single ACC cycle.
  always_comb begin
    in_acc    = (state_q == S_ACC);
    in_resp   = (state_q == S_RESP);

    gnt0      = in_acc & ~owner_q;
    gnt1      = in_acc &  owner_q;
    done0     = in_resp & ~owner_q;
    done1     = in_resp &  owner_q;
    err0      = done0 & err0_q;
    err1      = done1 & err1_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;

    mem_addr  = in_acc ? addr_q  : 32'd0;
    mem_wdata = in_acc ? wdata_q : 32'd0;
    mem_write = in_acc &  we_q & in_range;
    mem_read  = in_acc & ~we_q & in_range;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : randomized self-checking bench for dmem_arbiter against a
//                   transaction-level reference model and a reference memory
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int N_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        gnt0, done0, err0, gnt1, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [31:0] dmem    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[ADDR_W-1:0]];

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req[0]),
    .we0       (we[0]),
    .addr0     (addr[0]),
    .wdata0    (wdata[0]),
    .gnt0      (gnt0),
    .done0     (done0),
    .err0      (err0),
    .rdata0    (rdata0),
    .req1      (req[1]),
    .we1       (we[1]),
    .addr1     (addr[1]),
    .wdata1    (wdata[1]),
    .gnt1      (gnt1),
    .done1     (done1),
    .err1      (err1),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Transaction-level model: slot counts the cycles of the current access
  // (0 = no access in flight, 1 = memory cycle, 2 = response cycle).
  int          slot;
  logic        last_g;
  logic        who;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_inr;
  logic        exp_err;
  logic [31:0] exp_rd [2];
  logic [1:0]  pend;
  logic        did_acc_rst;

  task automatic model_step();
    if (reset) begin
      slot      = 0;
      last_g    = 1'b1;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      for (int n = 0; n < 2; n++)
        if (!req[n]) pend[n] = 1'b0;
    end else if (slot == 1) begin
      exp_rd[who] = (!t_we && t_inr) ? ref_mem[t_addr[ADDR_W-1:0]] : 32'd0;
      exp_err     = !t_inr;
      slot        = 2;
    end else if (slot == 2) begin
      slot = 0;
    end else if (req[0] || req[1]) begin
      who     = (req[0] && req[1]) ? !last_g : req[1];
      last_g  = who;
      t_we    = we[who];
      t_addr  = addr[who];
      t_wdata = wdata[who];
      t_inr   = ((t_addr >> ADDR_W) == 32'd0);
      // The memory write lands inside the access cycle, so a later reset cannot undo it.
      if (t_we && t_inr) ref_mem[t_addr[ADDR_W-1:0]] = t_wdata;
      slot = 1;
    end
  endtask

  task automatic compare_outputs();
    logic [7:0]  e_ctrl;
    logic [7:0]  o_ctrl;
    logic        acc;
    logic        rsp;
    acc    = (slot == 1);
    rsp    = (slot == 2);
    e_ctrl = {acc && !who, acc && who,
              rsp && !who, rsp && who,
              rsp && !who && exp_err, rsp && who && exp_err,
              acc && t_we && t_inr, acc && !t_we && t_inr};
    o_ctrl = {gnt0, gnt1, done0, done1, err0, err1, mem_write, mem_read};
    chk("ctrl{gnt0,gnt1,done0,done1,err0,err1,mw,mr}", 64'(o_ctrl), 64'(e_ctrl));
    chk("mem_addr",  64'(mem_addr),  acc ? 64'(t_addr)  : 64'd0);
    chk("mem_wdata", 64'(mem_wdata), acc ? 64'(t_wdata) : 64'd0);
    chk("rdata0",    64'(rdata0),    64'(exp_rd[0]));
    chk("rdata1",    64'(rdata1),    64'(exp_rd[1]));
  endtask

  task automatic new_request(input int n);
    pend[n]  = 1'b1;
    req[n]   = 1'b1;
    we[n]    = 1'($urandom_range(0, 1));
    addr[n]  = ($urandom_range(0, 4) == 0) ? ($urandom() | 32'h100)
                                           : 32'($urandom_range(0, DEPTH - 1));
    wdata[n] = $urandom();
  endtask

  task automatic drive(input int cyc);
    reset = (cyc < 1) || (cyc > 20 && $urandom_range(0, 79) == 0);
    if (!did_acc_rst && cyc >= 400 && slot == 1 && who == 1'b1) begin
      reset       = 1'b1;
      did_acc_rst = 1'b1;
    end
    for (int n = 0; n < 2; n++) begin
      if (slot == 2 && who == n[0]) begin
        req[n]  = 1'b0;
        pend[n] = 1'b0;
      end else if (slot == 1 && who == n[0]) begin
        // Latched request must be immune to anything the requester does now.
        we[n]    = 1'($urandom_range(0, 1));
        addr[n]  = $urandom();
        wdata[n] = $urandom();
        if ($urandom_range(0, 3) == 0) req[n] = 1'b0;
      end else if (!pend[n] && $urandom_range(0, 9) < 7) begin
        new_request(n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = $urandom();
      ref_mem[i] = dmem[i];
    end
    dmem[0]    = 32'd7;
    ref_mem[0] = 32'd7;

    slot        = 0;
    last_g      = 1'b1;
    who         = 1'b0;
    t_we        = 1'b0;
    t_addr      = 32'd0;
    t_wdata     = 32'd0;
    t_inr       = 1'b1;
    exp_err     = 1'b0;
    exp_rd[0]   = 32'd0;
    exp_rd[1]   = 32'd0;
    did_acc_rst = 1'b0;

    // Both requesters wait through reset: a read of word 0 and a write to word 5.
    reset    = 1'b1;
    req      = 2'b11;
    pend     = 2'b11;
    we       = 2'b10;
    addr[0]  = 32'd0;
    wdata[0] = 32'd0;
    addr[1]  = 32'd5;
    wdata[1] = 32'hDEAD_BEEF;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_outputs();
      drive(cyc);
      @(negedge clk);
      if (mem_write) dmem[mem_addr[ADDR_W-1:0]] = mem_wdata;
    end

    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem[%0d]", i), 64'(dmem[i]), 64'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
